alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_arb.sv | 165 ++++++++++++++++
 tb/tb_alu_share_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: two-requester front end for one shared Hack ALU.
// One operation is in flight at a time (IDLE -> EXEC -> RESP -> IDLE).
// The operands and control are registered toward the ALU. The ALU result and
// its flags are registered back as a response that is held until accepted.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration on ties.
// When it is not defined, requester 0 wins every tie.
module alu_share_arb #(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic [DW-1:0] req0_x_i,
  input  logic [DW-1:0] req0_y_i,
  input  logic [5:0]    req0_ctrl_i,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic [DW-1:0] req1_x_i,
  input  logic [DW-1:0] req1_y_i,
  input  logic [5:0]    req1_ctrl_i,
  output logic [DW-1:0] alu_x_o,
  output logic [DW-1:0] alu_y_o,
  output logic [5:0]    alu_ctrl_o,
  input  logic [DW-1:0] alu_out_i,
  input  logic          alu_zr_i,
  input  logic          alu_ng_i,
  output logic          resp_valid_o,
  output logic          resp_id_o,
  output logic [DW-1:0] resp_data_o,
  output logic          resp_zr_o,
  output logic          resp_ng_o,
  input  logic          resp_ready_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] alu_x_q, alu_x_d;
  logic [DW-1:0] alu_y_q, alu_y_d;
  logic [5:0]    alu_ctrl_q, alu_ctrl_d;
  logic          resp_id_q, resp_id_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic          resp_zr_q, resp_zr_d;
  logic          resp_ng_q, resp_ng_d;

  logic          any_req;
  logic          grant_id;

`ifdef ALU_ARB_RR_EN
  logic          last_q, last_d;
`endif

  // Arbitration: pick which pending requester would win a grant this cycle
  always_comb begin
    any_req = req0_valid_i | req1_valid_i;
`ifdef ALU_ARB_RR_EN
    if (req0_valid_i && req1_valid_i) begin
      grant_id = ~last_q;
    end else begin
      grant_id = req1_valid_i;
    end
`else
    grant_id = req1_valid_i & ~req0_valid_i;
`endif
  end

  // Next-state and output decode; registers hold unless a phase updates them
  always_comb begin
    state_d      = state_q;
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    alu_ctrl_d   = alu_ctrl_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_zr_d    = resp_zr_q;
    resp_ng_d    = resp_ng_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
`ifdef ALU_ARB_RR_EN
    last_d       = last_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // The reset term keeps the combinational accept pulses quiet while held in reset
        if (any_req && rst_n_i) begin
          req0_ready_o = ~grant_id;
          req1_ready_o = grant_id;
          alu_x_d      = grant_id ? req1_x_i    : req0_x_i;
          alu_y_d      = grant_id ? req1_y_i    : req0_y_i;
          alu_ctrl_d   = grant_id ? req1_ctrl_i : req0_ctrl_i;
          resp_id_d    = grant_id;
`ifdef ALU_ARB_RR_EN
          last_d       = grant_id;
`endif
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        resp_data_d = alu_out_i;
        resp_zr_d   = alu_zr_i;
        resp_ng_d   = alu_ng_i;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      alu_ctrl_q  <= '0;
      resp_id_q   <= 1'b0;
      resp_data_q <= '0;
      resp_zr_q   <= 1'b0;
      resp_ng_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      alu_ctrl_q  <= alu_ctrl_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      resp_zr_q   <= resp_zr_d;
      resp_ng_q   <= resp_ng_d;
    end
  end

`ifdef ALU_ARB_RR_EN
  // Last-grant register; resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign alu_x_o      = alu_x_q;
  assign alu_y_o      = alu_y_q;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign resp_id_o    = resp_id_q;
  assign resp_data_o  = resp_data_q;
  assign resp_zr_o    = resp_zr_q;
  assign resp_ng_o    = resp_ng_q;
  assign resp_valid_o = (state_q == ST_RESP);
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb.
// A Hack ALU model drives the DUT's ALU inputs. A transaction-level reference
// model checks every DUT output on every falling edge. Directed scenarios pin
// literal results. A random phase follows the directed scenarios.
// The arbitration policy follows the ALU_ARB_RR_EN macro.
module tb_alu_share_arb;
  localparam int DW = 16;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          req0_valid_i, req1_valid_i;
  logic          req0_ready_o, req1_ready_o;
  logic [DW-1:0] req0_x_i, req0_y_i, req1_x_i, req1_y_i;
  logic [5:0]    req0_ctrl_i, req1_ctrl_i;
  logic [DW-1:0] alu_x_o, alu_y_o, alu_out_i;
  logic [5:0]    alu_ctrl_o;
  logic          alu_zr_i, alu_ng_i;
  logic          resp_valid_o, resp_id_o, resp_zr_o, resp_ng_o, resp_ready_i, busy_o;
  logic [DW-1:0] resp_data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.DW(DW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_x_i(req0_x_i), .req0_y_i(req0_y_i), .req0_ctrl_i(req0_ctrl_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_x_i(req1_x_i), .req1_y_i(req1_y_i), .req1_ctrl_i(req1_ctrl_i),
    .alu_x_o(alu_x_o), .alu_y_o(alu_y_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_out_i(alu_out_i), .alu_zr_i(alu_zr_i), .alu_ng_i(alu_ng_i),
    .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o), .resp_data_o(resp_data_o),
    .resp_zr_o(resp_zr_o), .resp_ng_o(resp_ng_o), .resp_ready_i(resp_ready_i),
    .busy_o(busy_o)
  );

  function automatic logic [15:0] hack_f(input logic [15:0] x, input logic [15:0] y,
                                         input logic [5:0] c);
    logic [15:0] a, b, o;
    a = c[5] ? 16'h0000 : x;
    if (c[4]) a = ~a;
    b = c[3] ? 16'h0000 : y;
    if (c[2]) b = ~b;
    o = c[1] ? (a + b) : (a & b);
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_out_i = hack_f(alu_x_o, alu_y_o, alu_ctrl_o);
  assign alu_zr_i  = (alu_out_i == 16'h0000);
  assign alu_ng_i  = alu_out_i[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: at most one transaction, response two cycles after grant
  bit          m_busy = 1'b0;
  bit          m_resp = 1'b0;
  bit          m_last = 1'b1;
  logic        m_id   = 1'b0;
  logic [15:0] m_ax = '0, m_ay = '0, m_data = '0, m_pend = '0;
  logic [5:0]  m_ac = '0;
  logic        m_zr = 1'b0, m_ng = 1'b0;

  always @(negedge clk) begin : cmp
    logic e_r0, e_r1, g;
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    g    = 1'b0;
    if (!rst_n_i) begin
      m_busy = 1'b0; m_resp = 1'b0; m_last = 1'b1; m_id = 1'b0;
      m_ax = '0; m_ay = '0; m_ac = '0; m_data = '0; m_zr = 1'b0; m_ng = 1'b0;
    end else if (!m_busy && (req0_valid_i || req1_valid_i)) begin
      if (req0_valid_i && req1_valid_i) g = RR ? ~m_last : 1'b0;
      else                              g = req1_valid_i;
      e_r0 = ~g;
      e_r1 = g;
    end
    chk("ready0",     32'(req0_ready_o), 32'(e_r0));
    chk("ready1",     32'(req1_ready_o), 32'(e_r1));
    chk("busy",       32'(busy_o),       32'(m_busy));
    chk("resp_valid", 32'(resp_valid_o), 32'(m_busy && m_resp));
    chk("resp_id",    32'(resp_id_o),    32'(m_id));
    chk("resp_data",  32'(resp_data_o),  32'(m_data));
    chk("resp_zr",    32'(resp_zr_o),    32'(m_zr));
    chk("resp_ng",    32'(resp_ng_o),    32'(m_ng));
    chk("alu_x",      32'(alu_x_o),      32'(m_ax));
    chk("alu_y",      32'(alu_y_o),      32'(m_ay));
    chk("alu_ctrl",   32'(alu_ctrl_o),   32'(m_ac));
    if (rst_n_i) begin
      if (!m_busy) begin
        if (e_r0 || e_r1) begin
          m_busy = 1'b1; m_resp = 1'b0; m_id = g; m_last = g;
          m_ax = g ? req1_x_i : req0_x_i;
          m_ay = g ? req1_y_i : req0_y_i;
          m_ac = g ? req1_ctrl_i : req0_ctrl_i;
          m_pend = hack_f(m_ax, m_ay, m_ac);
        end
      end else if (!m_resp) begin
        m_resp = 1'b1;
        m_data = m_pend;
        m_zr   = (m_pend == 16'h0000);
        m_ng   = m_pend[15];
      end else if (resp_ready_i) begin
        m_busy = 1'b0;
        m_resp = 1'b0;
      end
    end
  end

  // Entered and left at posedge+1 with the DUT idle
  task automatic run_op(input bit who, input logic [15:0] x, input logic [15:0] y,
                        input logic [5:0] c, input logic [15:0] ed, input bit ezr,
                        input bit eng, input bit early, input int hold, input bit newreq);
    resp_ready_i = early;
    if (who) begin
      req1_valid_i = 1'b1; req1_x_i = x; req1_y_i = y; req1_ctrl_i = c;
    end else begin
      req0_valid_i = 1'b1; req0_x_i = x; req0_y_i = y; req0_ctrl_i = c;
    end
    @(negedge clk);
    chk("op_ready", 32'(who ? req1_ready_o : req0_ready_o), 32'd1);
    @(posedge clk); #1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    @(negedge clk);
    chk("op_exec_valid", 32'(resp_valid_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("op_valid", 32'(resp_valid_o), 32'd1);
    chk("op_id",    32'(resp_id_o),    32'(who));
    chk("op_data",  32'(resp_data_o),  32'(ed));
    chk("op_zr",    32'(resp_zr_o),    32'(ezr));
    chk("op_ng",    32'(resp_ng_o),    32'(eng));
    if (!early) begin
      for (int k = 1; k < hold; k++) begin
        @(posedge clk); #1;
        if (newreq) begin
          req0_valid_i = 1'b1;
          req0_x_i = 16'($urandom);
        end
        @(negedge clk);
        chk("bp_valid", 32'(resp_valid_o), 32'd1);
        chk("bp_data",  32'(resp_data_o),  32'(ed));
        if (newreq) chk("bp_ready0", 32'(req0_ready_o), 32'd0);
      end
      @(posedge clk); #1;
      req0_valid_i = 1'b0;
      resp_ready_i = 1'b1;
      @(negedge clk);
      chk("bp_last_valid", 32'(resp_valid_o), 32'd1);
    end
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ids [4];
    bit   got;
    int   waitc;
    rst_n_i = 1'b0;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; resp_ready_i = 1'b0;
    req0_x_i = '0; req0_y_i = '0; req0_ctrl_i = '0;
    req1_x_i = '0; req1_y_i = '0; req1_ctrl_i = '0;

    // Reference-model pins
    chk("hack_add",  32'(hack_f(16'd5, 16'd3, 6'b000010)), 32'h0008);
    chk("hack_sub",  32'(hack_f(16'd5, 16'd3, 6'b010011)), 32'h0002);
    chk("hack_m1",   32'(hack_f(16'd5, 16'd3, 6'b111010)), 32'hFFFF);
    chk("hack_zero", 32'(hack_f(16'h1234, 16'h5678, 6'b101010)), 32'h0000);

    @(negedge clk);
    chk("rst_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_busy",  32'(busy_o),       32'd0);
    chk("rst_alu_x", 32'(alu_x_o),      32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n_i = 1'b1;

    // Directed: add, zero with backpressure, subtract, minus one
    run_op(1'b0, 16'd5, 16'd3, 6'b000010, 16'h0008, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_op(1'b0, 16'h1234, 16'h5678, 6'b101010, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 1'b1);
    run_op(1'b1, 16'd5, 16'd3, 6'b010011, 16'h0002, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_op(1'b1, 16'd5, 16'd3, 6'b111010, 16'hFFFF, 1'b0, 1'b1, 1'b1, 0, 1'b0);

    // Tie: both requesters valid for four operations
    req0_valid_i = 1'b1; req0_x_i = 16'd7; req0_y_i = 16'd1; req0_ctrl_i = 6'b000010;
    req1_valid_i = 1'b1; req1_x_i = 16'd9; req1_y_i = 16'd2; req1_ctrl_i = 6'b000000;
    resp_ready_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      waitc = 0;
      ids[n] = 1'b0;
      while (!got && waitc < 10) begin
        @(negedge clk);
        if (req0_ready_o || req1_ready_o) begin
          ids[n] = req1_ready_o;
          got = 1'b1;
        end else begin
          @(posedge clk); #1;
          waitc++;
        end
      end
      chk("tie_grant_seen", 32'(got), 32'd1);
      chk("tie_id", 32'(ids[n]), RR ? 32'(n % 2) : 32'd0);
      @(posedge clk); #1;
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    resp_ready_i = 1'b0;

    // Reset during EXEC aborts the operation
    req0_valid_i = 1'b1; req0_x_i = 16'd9; req0_y_i = 16'd9; req0_ctrl_i = 6'b000010;
    @(negedge clk);
    chk("abort_grant", 32'(req0_ready_o), 32'd1);
    @(posedge clk); #1;
    req0_valid_i = 1'b0;
    #1 rst_n_i = 1'b0;
    @(negedge clk);
    chk("abort_busy",  32'(busy_o),       32'd0);
    chk("abort_valid", 32'(resp_valid_o), 32'd0);
    chk("abort_alu_x", 32'(alu_x_o),      32'd0);
    chk("abort_id",    32'(resp_id_o),    32'd0);
    @(posedge clk); #1;
    rst_n_i = 1'b1;
    resp_ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_valid_o), 32'd0);
      @(posedge clk); #1;
    end
    run_op(1'b1, 16'h00F0, 16'h000F, 6'b000010, 16'h00FF, 1'b0, 1'b0, 1'b1, 0, 1'b0);

    // Random phase: arbitrary valids, backpressure, dropped requests, resets
    for (int c = 0; c < 400; c++) begin
      req0_valid_i = ($urandom_range(0, 2) != 0);
      req1_valid_i = ($urandom_range(0, 2) != 0);
      req0_x_i = 16'($urandom); req0_y_i = 16'($urandom); req0_ctrl_i = 6'($urandom);
      req1_x_i = 16'($urandom); req1_y_i = 16'($urandom); req1_ctrl_i = 6'($urandom);
      resp_ready_i = ($urandom_range(0, 1) != 0);
      rst_n_i = ($urandom_range(0, 99) != 0);
      @(posedge clk); #1;
    end
    rst_n_i = 1'b1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    resp_ready_i = 1'b1;
    repeat (5) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
